// File: rtl/popcount_ctrl_pkg.sv
// popcount_ctrl_pkg: shared states, core widths and width helper for the popcount neuron controller
package popcount_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, POS, NEG, RESULT} state_t;
  localparam int PC_IN_W = 22;
  localparam int PC_CNT_W = 5;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/sat_acc.sv
// sat_acc: unsigned saturating accumulator with clear and enable
module sat_acc #(parameter int ACC_W = 8) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [ACC_W-1:0] add,
  output logic [ACC_W-1:0] acc,
  output logic [ACC_W-1:0] nxt
);
  logic [ACC_W:0] sum;
  always_comb begin
    sum = {1'b0, acc} + {1'b0, add};
    nxt = clr ? '0 : en ? (sum[ACC_W] ? '1 : sum[ACC_W-1:0]) : acc;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) acc <= '0;
    else acc <= nxt;
endmodule

// File: rtl/popcount22_neuron_seq.sv
// popcount22_neuron_seq: time-shares an external popcount22 core to evaluate a multi-chunk ternary neuron
module popcount22_neuron_seq
  import popcount_ctrl_pkg::*;
#(
  parameter int CHUNKS = 4,
  parameter int ACC_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ACC_W:0]      thr,
  output logic                busy,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PC_IN_W-1:0]  in_pos,
  input  logic [PC_IN_W-1:0]  in_neg,
  output logic [PC_IN_W-1:0]  pc_in,
  input  logic [PC_CNT_W-1:0] pc_cnt,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_W:0]      out_sum,
  output logic                out_act
);
  localparam int CW = CHUNKS > 1 ? clog2(CHUNKS) : 1;
  state_t state;
  logic [CW-1:0] chunk_cnt;
  logic [PC_IN_W-1:0] pos_reg, neg_reg;
  logic [ACC_W:0] thr_r, diff;
  logic [ACC_W-1:0] cnt, pos_acc, neg_acc, pos_nxt, neg_nxt;
  logic clr;
  assign cnt = ACC_W'(pc_cnt);
  assign clr = state == IDLE && start;
  assign busy = state != IDLE;
  assign in_ready = state == LOAD;
  assign out_valid = state == RESULT;
  assign pc_in = state == POS ? pos_reg : state == NEG ? neg_reg : '0;
  // Uses next-state accumulator values so the result registers in the final NEG cycle.
  assign diff = {1'b0, pos_nxt} - {1'b0, neg_nxt};
  sat_acc #(.ACC_W(ACC_W)) u_pos (
    .clk(clk), .rst(rst), .clr(clr), .en(state == POS), .add(cnt), .acc(pos_acc), .nxt(pos_nxt)
  );
  sat_acc #(.ACC_W(ACC_W)) u_neg (
    .clk(clk), .rst(rst), .clr(clr), .en(state == NEG), .add(cnt), .acc(neg_acc), .nxt(neg_nxt)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      chunk_cnt <= '0;
      pos_reg <= '0;
      neg_reg <= '0;
      thr_r <= '0;
      out_sum <= '0;
      out_act <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          thr_r <= thr;
          chunk_cnt <= '0;
          state <= LOAD;
        end
        LOAD: if (in_valid) begin
          pos_reg <= in_pos;
          neg_reg <= in_neg;
          state <= POS;
        end
        POS: state <= NEG;
        NEG: if (chunk_cnt == CW'(CHUNKS - 1)) begin
          out_sum <= diff;
          out_act <= $signed(diff) >= $signed(thr_r);
          state <= RESULT;
        end else begin
          chunk_cnt <= chunk_cnt + CW'(1);
          state <= LOAD;
        end
        RESULT: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_popcount22_neuron_seq.sv
// tb_popcount22_neuron_seq: directed and random checks against a sum-of-popcounts reference
module tb_popcount22_neuron_seq;
  logic clk = 0, rst = 1;
  logic start, in_valid, out_ready, busy, in_ready, out_valid, out_act;
  logic signed [8:0] thr;
  logic [8:0] out_sum;
  logic [21:0] in_pos, in_neg, pc_in;
  logic [4:0] pc_cnt;
  logic s_start, s_in_valid, s_out_ready, s_busy, s_in_ready, s_out_valid, s_out_act;
  logic [6:0] s_thr, s_out_sum;
  logic [21:0] s_in_pos, s_in_neg, s_pc_in;
  logic [4:0] s_pc_cnt;
  int compared = 0, mismatched = 0, cyc = 0;
  logic [21:0] vp[4], vn[4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign pc_cnt = 5'($countones(pc_in));
  assign s_pc_cnt = s_pc_in != 0 ? 5'd31 : 5'd0;

  popcount22_neuron_seq #(.CHUNKS(4), .ACC_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .thr(thr), .busy(busy), .in_valid(in_valid),
    .in_ready(in_ready), .in_pos(in_pos), .in_neg(in_neg), .pc_in(pc_in), .pc_cnt(pc_cnt),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_act(out_act)
  );
  popcount22_neuron_seq #(.CHUNKS(4), .ACC_W(6)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .thr(s_thr), .busy(s_busy), .in_valid(s_in_valid),
    .in_ready(s_in_ready), .in_pos(s_in_pos), .in_neg(s_in_neg), .pc_in(s_pc_in), .pc_cnt(s_pc_cnt),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_sum(s_out_sum), .out_act(s_out_act)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int total, input int w);
    return total > (1 << w) - 1 ? (1 << w) - 1 : total;
  endfunction

  task automatic run_eval(input logic signed [8:0] t, input int stall_k, input int ostall,
                          input bit sp, input bit sr, input bit chk_lat);
    int tp, tn, es, n, t0;
    bit ea;
    tp = 0;
    tn = 0;
    for (int k = 0; k < 4; k++) begin
      tp += $countones(vp[k]);
      tn += $countones(vn[k]);
    end
    es = sat(tp, 8) - sat(tn, 8);
    ea = es >= int'(t);
    thr = t;
    start = 1;
    t0 = cyc;
    tick;
    start = 0;
    chk("busy_after_start", busy, 1);
    in_valid = 1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!in_ready && n < 20) begin tick; n++; end
      if (k == stall_k) begin
        in_valid = 0;
        for (int i = 0; i < 5; i++) begin chk("in_ready_stall", in_ready, 1); tick; end
        in_valid = 1;
      end
      chk("in_ready", in_ready, 1);
      in_pos = vp[k];
      in_neg = vn[k];
      tick;
      start = sp && k == 1;
      chk("pc_in_pos", pc_in, vp[k]);
      tick;
      start = 0;
      chk("pc_in_neg", pc_in, vn[k]);
      tick;
    end
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 20) begin tick; n++; end
    chk("out_valid", out_valid, 1);
    if (chk_lat) chk("latency", cyc - t0, 13);
    chk("out_sum", $signed(out_sum), es);
    chk("out_act", out_act, ea);
    out_ready = 0;
    for (int i = 0; i < ostall; i++) begin
      tick;
      chk("out_valid_held", out_valid, 1);
      chk("out_sum_held", $signed(out_sum), es);
    end
    out_ready = 1;
    start = sr;
    tick;
    start = 0;
    out_ready = 0;
    chk("out_valid_drop", out_valid, 0);
    chk("busy_drop", busy, 0);
    tick;
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    int n;
    start = 0; in_valid = 0; in_pos = 0; in_neg = 0; out_ready = 0; thr = 0;
    s_start = 0; s_in_valid = 0; s_in_pos = 0; s_in_neg = 0; s_out_ready = 0; s_thr = 0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_pc_in", pc_in, 0);
    @(posedge clk);
    #1 rst = 0;
    tick;
    for (int k = 0; k < 4; k++) begin vp[k] = 22'h3FFFFF; vn[k] = 0; end
    run_eval(9'sd0, -1, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) begin vp[k] = 22'h000003; vn[k] = 22'h00000F; end
    run_eval(-9'sd4, 2, 4, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin vp[k] = 22'($urandom); vn[k] = 22'($urandom) | 22'h1; end
    thr = 0;
    start = 1;
    tick;
    start = 0;
    in_valid = 1;
    in_pos = vp[0]; in_neg = vn[0];
    tick; tick; tick;
    in_pos = vp[1]; in_neg = vn[1];
    tick; tick;
    chk("pc_in_pre_rst", pc_in, vn[1]);
    #2 rst = 1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_sum", out_sum, 0);
    chk("arst_out_act", out_act, 0);
    chk("arst_pc_in", pc_in, 0);
    in_valid = 0;
    @(posedge clk);
    #1 rst = 0;
    tick;
    for (int k = 0; k < 4; k++) begin vp[k] = 22'($urandom); vn[k] = 22'($urandom); end
    run_eval(9'($urandom), -1, 0, 1, 1, 1);
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) begin vp[k] = 22'($urandom); vn[k] = 22'($urandom); end
      run_eval(9'($urandom_range(0, 80)) - 9'sd40, r == 1 ? 0 : -1, r, 0, 0, 0);
    end
    s_in_valid = 1;
    s_in_pos = 22'($urandom) | 22'h1;
    s_in_neg = 0;
    s_start = 1;
    tick;
    s_start = 0;
    n = 0;
    while (!s_out_valid && n < 40) begin tick; n++; end
    chk("sat_out_valid", s_out_valid, 1);
    chk("sat_out_sum", $signed(s_out_sum), sat(31 * 4, 6) - 0);
    chk("sat_out_act", s_out_act, 1);
    s_out_ready = 1;
    tick;
    s_out_ready = 0;
    s_in_valid = 0;
    chk("sat_out_valid_drop", s_out_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
